// File: rtl/melody_player_if.sv
// melody_player_if: control, RAM write port and status bundle of the melody player.
//   master : board-side logic (buttons/switches, RAM loader); drives controls and writes.
//   slave  : the melody player itself; drives the buzzer and status outputs.
// Signals:
//   play/pause/stop  one-cycle command pulses, no acknowledge: a pulse is acted on
//                    in the cycle it is high if the current state accepts it,
//                    otherwise it is dropped (stop > pause > play when coincident)
//   loop             level, sampled when the last entry completes
//   octave           right-shift applied to the half-period when a note loads
//   wr_en/wr_addr/wr_data  note RAM write port, {last, dur, half}
//   buzzer           square-wave tone
//   busy             high whenever the player is not idle
//   note_idx         address of the entry being played
//   done             one-cycle pulse after the last entry completes
//   dbg_state        current FSM state encoding
interface melody_player_if #(
    parameter int ADDR_W = 6,
    parameter int HALF_W = 20,
    parameter int DUR_W  = 8
);
    logic                      play;
    logic                      pause;
    logic                      stop;
    logic                      loop;
    logic [1:0]                octave;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DUR_W+HALF_W:0]     wr_data;
    logic                      buzzer;
    logic                      busy;
    logic [ADDR_W-1:0]         note_idx;
    logic                      done;
    logic [2:0]                dbg_state;

    modport master (
        output play, pause, stop, loop, octave, wr_en, wr_addr, wr_data,
        input  buzzer, busy, note_idx, done, dbg_state
    );

    modport slave (
        input  play, pause, stop, loop, octave, wr_en, wr_addr, wr_data,
        output buzzer, busy, note_idx, done, dbg_state
    );
endinterface

// File: rtl/melody_player.sv
// melody_player: plays a melody stored in an internal note RAM as a square wave.
// Ports:
//   clk  board clock, all logic on the rising edge
//   rst  synchronous active-high reset (RAM contents are kept)
//   bus  melody_player_if slave: commands, RAM write port, buzzer and status
// Each RAM entry is {last, dur, half}; half=0 is a rest. A note lasts max(dur,1)
// ticks of TICK_CYCLES clocks; the last GAP_TICKS ticks of each note are silent.
module melody_player #(
    parameter int ADDR_W      = 6,
    parameter int HALF_W      = 20,
    parameter int DUR_W       = 8,
    parameter int TICK_CYCLES = 2_500_000,
    parameter int GAP_TICKS   = 1
) (
    input  logic        clk,
    input  logic        rst,
    melody_player_if.slave bus
);
    localparam int ENTRY_W = 1 + DUR_W + HALF_W;
    localparam int TICK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_PLAY   = 3'd3,
        S_PAUSED = 3'd4
    } state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   idx, idx_d;
    logic [TICK_W-1:0]   tick_cnt, tick_d;
    logic [DUR_W-1:0]    dur_cnt, dur_d;
    logic [HALF_W-1:0]   tone_cnt, tone_d;
    logic                phase, phase_d;
    logic                done_r, done_d;
    logic                buzzer_r, buzzer_d;
    logic                busy_r;

    logic [ENTRY_W-1:0]  mem [0:2**ADDR_W-1];
    logic [ENTRY_W-1:0]  rd_data;

    // Entry fields latched in LOAD
    logic                last_r;
    logic                rest_r;
    logic [HALF_W-1:0]   half_r;
    logic [DUR_W-1:0]    dur_r;

    logic [HALF_W-1:0]   ld_half, ld_h;
    logic [DUR_W-1:0]    ld_dur, ld_d;
    logic                silent_cur, silent_nxt;

    // Note RAM: writes at any time, registered read issued in FETCH
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        if (state == S_FETCH) begin
            rd_data <= mem[idx];
        end
    end

    // Transposed half-period and effective duration of the fetched entry
    always_comb begin
        ld_half = rd_data[HALF_W-1:0];
        ld_dur  = rd_data[HALF_W +: DUR_W];
        ld_h    = ld_half >> bus.octave;
        if (ld_half != '0 && ld_h == '0) begin
            ld_h = HALF_W'(1);
        end
        ld_d = (ld_dur == '0) ? DUR_W'(1) : ld_dur;
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        tick_d   = tick_cnt;
        dur_d    = dur_cnt;
        tone_d   = tone_cnt;
        phase_d  = phase;
        done_d   = 1'b0;
        // Silent for rests and for the trailing GAP_TICKS ticks; the comparison
        // also covers notes no longer than the gap.
        silent_cur = rest_r || ((32'(dur_cnt) + 32'(GAP_TICKS)) >= 32'(dur_r));

        case (state)
            S_IDLE: begin
                if (bus.play) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_PLAY;
                tick_d  = '0;
                dur_d   = '0;
                tone_d  = '0;
                phase_d = 1'b0;
            end
            S_PLAY: begin
                if (!silent_cur) begin
                    if (tone_cnt == half_r - HALF_W'(1)) begin
                        tone_d  = '0;
                        phase_d = ~phase;
                    end else begin
                        tone_d = tone_cnt + HALF_W'(1);
                    end
                end
                if (tick_cnt == TICK_LAST) begin
                    tick_d = '0;
                    if (dur_cnt == dur_r - DUR_W'(1)) begin
                        if (!last_r) begin
                            idx_d   = idx + ADDR_W'(1);
                            state_d = S_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            idx_d   = '0;
                            state_d = bus.loop ? S_FETCH : S_IDLE;
                        end
                    end else begin
                        dur_d = dur_cnt + DUR_W'(1);
                    end
                end else begin
                    tick_d = tick_cnt + TICK_W'(1);
                end
                // The cycle carrying the pause still counts as a played cycle;
                // a pause landing on the final cycle of a note is overtaken by
                // the note ending.
                if (bus.pause && state_d == S_PLAY) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (bus.play) begin
                    state_d = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.stop) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b0;
        end

        // Buzzer is registered from next-cycle values so it never lags the gap
        silent_nxt = rest_r || ((32'(dur_d) + 32'(GAP_TICKS)) >= 32'(dur_r));
        buzzer_d   = (state_d == S_PLAY) && phase_d && !silent_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            phase    <= 1'b0;
            done_r   <= 1'b0;
            buzzer_r <= 1'b0;
            busy_r   <= 1'b0;
            last_r   <= 1'b0;
            rest_r   <= 1'b0;
            half_r   <= '0;
            dur_r    <= '0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            tick_cnt <= tick_d;
            dur_cnt  <= dur_d;
            tone_cnt <= tone_d;
            phase    <= phase_d;
            done_r   <= done_d;
            buzzer_r <= buzzer_d;
            busy_r   <= (state_d != S_IDLE);
            if (state == S_LOAD) begin
                last_r <= rd_data[ENTRY_W-1];
                rest_r <= (ld_half == '0);
                half_r <= ld_h;
                dur_r  <= ld_d;
            end
        end
    end

    assign bus.buzzer    = buzzer_r;
    assign bus.busy      = busy_r;
    assign bus.note_idx  = idx;
    assign bus.done      = done_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: directed checks of melody_player with small parameters.
// dut0 uses GAP_TICKS=0, dut1 uses GAP_TICKS=1; both share the same stimulus.
module tb_melody_player;
    logic       clk;
    logic       rst;
    logic       play, pause, stop, loop;
    logic [1:0] octave;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    int checks;
    int failures;

    typedef struct {
        logic       play;
        logic       pause;
        logic       stop;
        logic       exp_buz;
        logic       exp_busy;
        logic       exp_done;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] exp_q[$];

    melody_player_if #(.ADDR_W(3), .HALF_W(4), .DUR_W(3)) bus0();
    melody_player_if #(.ADDR_W(3), .HALF_W(4), .DUR_W(3)) bus1();

    assign bus0.play = play;     assign bus1.play = play;
    assign bus0.pause = pause;   assign bus1.pause = pause;
    assign bus0.stop = stop;     assign bus1.stop = stop;
    assign bus0.loop = loop;     assign bus1.loop = loop;
    assign bus0.octave = octave; assign bus1.octave = octave;
    assign bus0.wr_en = wr_en;   assign bus1.wr_en = wr_en;
    assign bus0.wr_addr = wr_addr; assign bus1.wr_addr = wr_addr;
    assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;

    melody_player #(.ADDR_W(3), .HALF_W(4), .DUR_W(3), .TICK_CYCLES(4), .GAP_TICKS(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    melody_player #(.ADDR_W(3), .HALF_W(4), .DUR_W(3), .TICK_CYCLES(4), .GAP_TICKS(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_entry(input logic [2:0] a, input logic l, input logic [2:0] d, input logic [3:0] h);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = {l, d, h};
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic void add(input logic pl, input logic pa, input logic st,
                                input logic bz, input logic by, input logic dn, input logic [2:0] ix);
        vec_t v;
        v.play = pl; v.pause = pa; v.stop = st;
        v.exp_buz = bz; v.exp_busy = by; v.exp_done = dn; v.exp_idx = ix;
        vecs.push_back(v);
    endfunction

    // Applies the table one vector per clock and compares the selected DUT
    task automatic run_table(input int sel, input string tag);
        logic [5:0] e;
        logic       buz, busy, done;
        logic [2:0] idx;
        foreach (vecs[i]) begin
            play  = vecs[i].play;
            pause = vecs[i].pause;
            stop  = vecs[i].stop;
            exp_q.push_back({vecs[i].exp_buz, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_idx});
            step();
            e    = exp_q.pop_front();
            buz  = sel ? bus1.buzzer   : bus0.buzzer;
            busy = sel ? bus1.busy     : bus0.busy;
            done = sel ? bus1.done     : bus0.done;
            idx  = sel ? bus1.note_idx : bus0.note_idx;
            check($sformatf("%s v%0d buzzer", tag, i), buz,  e[5]);
            check($sformatf("%s v%0d busy",   tag, i), busy, e[4]);
            check($sformatf("%s v%0d done",   tag, i), done, e[3]);
            check($sformatf("%s v%0d idx",    tag, i), idx,  e[2:0]);
        end
        vecs.delete();
        play = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        play = 0; pause = 0; stop = 0; loop = 0; octave = 2'd0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("reset buzzer", bus0.buzzer, 0);
        check("reset busy", bus0.busy, 0);
        check("reset done", bus0.done, 0);
        check("reset idx", bus0.note_idx, 0);
        check("reset busy dut1", bus1.busy, 0);

        // Single note {1,2,3}: tone period 6, 8 PLAY cycles, then done
        write_entry(3'd0, 1'b1, 3'd2, 4'd3);
        add(1,0,0, 0,1,0,0);
        add(0,0,0, 0,1,0,0);
        add(0,0,0, 0,1,0,0); add(0,0,0, 0,1,0,0); add(0,0,0, 0,1,0,0); add(0,0,0, 1,1,0,0);
        add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0); add(0,0,0, 0,1,0,0); add(0,0,0, 0,1,0,0);
        add(0,0,0, 0,0,1,0);
        add(0,0,0, 0,0,0,0);
        run_table(0, "single");

        // Reset mid-note, then rest + octave program restarts from address 0
        write_entry(3'd0, 1'b0, 3'd1, 4'd0);
        write_entry(3'd1, 1'b1, 3'd1, 4'd6);
        octave = 2'd1;
        play = 1'b1;
        step();
        play = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("pre-reset idx", bus0.note_idx, 1);
        do_reset();
        check("midreset buzzer", bus0.buzzer, 0);
        check("midreset busy", bus0.busy, 0);
        check("midreset done", bus0.done, 0);
        check("midreset idx", bus0.note_idx, 0);

        add(1,0,0, 0,1,0,0);
        add(0,0,0, 0,1,0,0);
        for (int i = 0; i < 4; i++) add(0,0,0, 0,1,0,0);
        add(0,0,0, 0,1,0,1);
        add(0,0,0, 0,1,0,1);
        add(0,0,0, 0,1,0,1); add(0,0,0, 0,1,0,1); add(0,0,0, 0,1,0,1); add(0,0,0, 1,1,0,1);
        add(0,0,0, 0,0,1,0);
        run_table(0, "rest_oct");
        octave = 2'd0;

        // Loop: two one-tick notes, 12 cycles per pass; loop dropped late
        write_entry(3'd0, 1'b0, 3'd1, 4'd2);
        write_entry(3'd1, 1'b1, 3'd1, 4'd2);
        for (int i = 0; i < 50; i++) begin
            play = (i == 0);
            loop = (i < 38);
            step();
            play = 1'b0;
            check($sformatf("loop c%0d busy", i), bus0.busy, (i < 48) ? 1 : 0);
            check($sformatf("loop c%0d done", i), bus0.done,
                  (i == 12 || i == 24 || i == 36 || i == 48) ? 1 : 0);
            check($sformatf("loop c%0d idx", i), bus0.note_idx, (i < 48 && (i % 12) >= 6) ? 1 : 0);
        end
        loop = 1'b0;

        // Pause 5 cycles into a 12-cycle note, hold 20, resume for 7 cycles
        write_entry(3'd0, 1'b1, 3'd3, 4'd2);
        add(1,0,0, 0,1,0,0);
        add(0,0,0, 0,1,0,0);
        add(0,0,0, 0,1,0,0); add(0,0,0, 0,1,0,0); add(1,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0);
        add(0,0,0, 0,1,0,0);
        add(0,1,0, 0,1,0,0);
        for (int i = 0; i < 19; i++) add(0,0,0, 0,1,0,0);
        add(1,0,0, 0,1,0,0); add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0); add(0,0,0, 0,1,0,0);
        add(0,0,0, 0,1,0,0); add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0);
        add(0,0,0, 0,0,1,0);
        run_table(0, "pause");

        // Stop and Play together mid-note: stop wins, no done
        play = 1'b1;
        step();
        play = 1'b0;
        step(); step(); step();
        stop = 1'b1; play = 1'b1;
        step();
        check("stop+play busy", bus0.busy, 0);
        check("stop+play done", bus0.done, 0);
        check("stop+play buzzer", bus0.buzzer, 0);
        step();
        check("stop+play idle busy", bus0.busy, 0);
        stop = 1'b0; play = 1'b0;
        step();
        check("after stop done", bus0.done, 0);

        // Pause outside PLAY is ignored
        play = 1'b1;
        step();
        play = 1'b0; pause = 1'b1;
        step();
        pause = 1'b0;
        check("pause in fetch busy", bus0.busy, 1);
        step(); step(); step();
        check("pause in fetch ignored buzzer", bus0.buzzer, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop from play busy", bus0.busy, 0);

        // Articulation gap on dut1: 8 tone cycles + 4 silent, then a silent 1-tick note
        do_reset();
        write_entry(3'd0, 1'b0, 3'd3, 4'd2);
        write_entry(3'd1, 1'b1, 3'd1, 4'd2);
        add(1,0,0, 0,1,0,0);
        add(0,0,0, 0,1,0,0);
        add(0,0,0, 0,1,0,0); add(0,0,0, 0,1,0,0); add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0);
        add(0,0,0, 0,1,0,0); add(0,0,0, 0,1,0,0); add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0);
        for (int i = 0; i < 4; i++) add(0,0,0, 0,1,0,0);
        add(0,0,0, 0,1,0,1);
        add(0,0,0, 0,1,0,1);
        for (int i = 0; i < 4; i++) add(0,0,0, 0,1,0,1);
        add(0,0,0, 0,0,1,0);
        run_table(1, "gap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
